// File: rtl/gray_sobel_edge.sv
// 3x3 Sobel edge detector on a raster gray pixel stream, two-line buffered, thresholded
// to binary white/black; en=0 passes pixels through with the same two-cycle latency.
module gray_sobel_edge #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned THRESH     = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] pix_in,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic [23:0] edge_out,
  output logic        out_valid,
  output logic        out_sof,
  output logic        frame_done
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, cur_x;
  logic [YW-1:0]   y_q, y_d, cur_y;
  logic            accept, last_px;

  logic [7:0]      lb1 [IMG_WIDTH];  // row y-1
  logic [7:0]      lb2 [IMG_WIDTH];  // row y-2
  logic [7:0]      col_top, col_mid, col_bot;
  logic [7:0]      w1_top_q, w1_mid_q, w1_bot_q;  // column x-1
  logic [7:0]      w2_top_q, w2_mid_q, w2_bot_q;  // column x-2

  logic [12:0]     gx_p, gx_n, gy_p, gy_n;
  logic [12:0]     ax, ay;
  logic [11:0]     mag;
  logic            is_edge;

  logic            v1_q, sof1_q, done1_q, edge1_q, en1_q;
  logic [23:0]     pix1_q;

  // Frame sequencing; a sof pixel always restarts at (0,0), even mid-frame.
  always_comb begin
    accept  = pix_valid & (pix_sof | (state_q == StActive));
    cur_x   = pix_sof ? '0 : x_q;
    cur_y   = pix_sof ? '0 : y_q;
    last_px = (cur_x == XW'(IMG_WIDTH - 1)) && (cur_y == YW'(IMG_HEIGHT - 1));
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (accept) begin
      if (last_px) begin
        state_d = StIdle;
        x_d     = '0;
        y_d     = '0;
      end else begin
        state_d = StActive;
        if (cur_x == XW'(IMG_WIDTH - 1)) begin
          x_d = '0;
          y_d = cur_y + 1'b1;
        end else begin
          x_d = cur_x + 1'b1;
          y_d = cur_y;
        end
      end
    end
  end

  // Newest window column: buffered rows above plus the incoming pixel.
  always_comb begin
    col_top = lb2[cur_x];
    col_mid = lb1[cur_x];
    col_bot = pix_in[7:0];
  end

  always_comb begin
    gx_p = 13'(col_top) + (13'(col_mid) << 1) + 13'(col_bot);
    gx_n = 13'(w2_top_q) + (13'(w2_mid_q) << 1) + 13'(w2_bot_q);
    gy_p = 13'(w2_bot_q) + (13'(w1_bot_q) << 1) + 13'(col_bot);
    gy_n = 13'(w2_top_q) + (13'(w1_top_q) << 1) + 13'(col_top);
    ax   = (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
    ay   = (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
    mag  = ax[11:0] + ay[11:0];
    // Windows touching the top two rows or left two columns hold stale data.
    is_edge = (mag >= 12'(THRESH)) && (cur_x >= XW'(2)) && (cur_y >= YW'(2));
  end

  // Line buffers and window are not reset; the border mask hides stale contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_x] <= pix_in[7:0];
      lb2[cur_x] <= lb1[cur_x];
      w2_top_q   <= w1_top_q;
      w2_mid_q   <= w1_mid_q;
      w2_bot_q   <= w1_bot_q;
      w1_top_q   <= col_top;
      w1_mid_q   <= col_mid;
      w1_bot_q   <= col_bot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      v1_q       <= 1'b0;
      sof1_q     <= 1'b0;
      done1_q    <= 1'b0;
      edge1_q    <= 1'b0;
      en1_q      <= 1'b0;
      pix1_q     <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      edge_out   <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      v1_q       <= accept;
      sof1_q     <= accept & pix_sof;
      done1_q    <= accept & last_px;
      edge1_q    <= is_edge;
      en1_q      <= en;
      pix1_q     <= pix_in;
      out_valid  <= v1_q;
      out_sof    <= v1_q & sof1_q;
      frame_done <= v1_q & done1_q;
      if (!v1_q)      edge_out <= '0;
      else if (en1_q) edge_out <= {24{edge1_q}};
      else            edge_out <= pix1_q;
    end
  end

endmodule

// File: tb/tb_gray_sobel_edge.sv
// Scoreboard bench for gray_sobel_edge on an 8x4 frame: the driver queues hand-derived
// expected pixels with their due cycle, the monitor pops and compares on each output.
module tb_gray_sobel_edge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [23:0] pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [23:0] edge_out;
  logic        out_valid, out_sof, frame_done;

  typedef struct {
    logic [23:0] d;
    logic        sof;
    logic        done;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic fin = 1'b0;

  gray_sobel_edge #(
    .IMG_WIDTH (8),
    .IMG_HEIGHT(4),
    .THRESH    (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .edge_out  (edge_out),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Patterns: 0 uniform 0x80, 1 step to 0xFF, 2 step to 0x19, 3 step to 0x18, 4 ramp.
  function automatic logic [23:0] pval(input int pat, input int x, input int y);
    logic [23:0] base;
    base = 24'h123456;
    case (pat)
      0:       return 24'h808080;
      1:       return (x >= 4) ? 24'hFFFFFF : 24'h000000;
      2:       return (x >= 4) ? 24'h191919 : 24'h000000;
      3:       return (x >= 4) ? 24'h181818 : 24'h000000;
      default: return base + 24'(x + 8 * y) * 24'h010203;
    endcase
  endfunction

  // Step of 0xFF (mag 1020) or 0x19 (mag 100) lights output columns 4,5 from row 2.
  function automatic logic [23:0] eval(input int pat, input int x, input int y, input logic e);
    if (!e) return pval(pat, x, y);
    if ((pat == 1 || pat == 2) && (x == 4 || x == 5) && y >= 2) return 24'hFFFFFF;
    return 24'h000000;
  endfunction

  task automatic drive(input logic [23:0] p, input logic v, input logic s, input logic e,
                       input logic push, input logic [23:0] ed, input logic es,
                       input logic edn);
    exp_t it;
    @(posedge clk);
    #1;
    pix_in    = p;
    pix_valid = v;
    pix_sof   = s;
    en        = e;
    if (push) begin
      it.d = ed; it.sof = es; it.done = edn; it.due = cyc + 2;
      q.push_back(it);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(24'h0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int pat, input logic e, input int npix, input int gap_every);
    int x, y;
    for (int i = 0; i < npix; i++) begin
      x = i % 8;
      y = i / 8;
      if (gap_every > 0 && (i % gap_every) == gap_every - 1) idle(1);
      drive(pval(pat, x, y), 1'b1, i == 0, e, 1'b1, eval(pat, x, y, e), i == 0, i == 31);
    end
  endtask

  always @(negedge clk) begin
    exp_t it;
    if (rst) begin
      checks++;
      if (out_valid !== 1'b0 || edge_out !== 24'h0 || out_sof !== 1'b0
          || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got v=%b d=%h sof=%b done=%b, want all 0",
                 out_valid, edge_out, out_sof, frame_done);
      end
    end else if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output at cycle %0d: got d=%h, want no output", cyc, edge_out);
      end else begin
        it = q.pop_front();
        if (edge_out !== it.d || out_sof !== it.sof || frame_done !== it.done
            || cyc != it.due) begin
          errors++;
          $display("FAIL output_pixel: got d=%h sof=%b done=%b cyc=%0d, want d=%h sof=%b done=%b cyc=%0d",
                   edge_out, out_sof, frame_done, cyc, it.d, it.sof, it.done, it.due);
        end
      end
    end else begin
      if (out_sof !== 1'b0 || frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL flags_without_valid: got sof=%b done=%b, want 0 0", out_sof, frame_done);
      end
      if (q.size() > 0 && q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_output: got no valid at cycle %0d, want d=%h due %0d",
                 cyc, q[0].d, q[0].due);
        void'(q.pop_front());
      end
    end
    if (fin) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL leftover_expected: got %0d pending, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    idle(3);
    @(posedge clk); #1 rst = 1'b0;
    // Pixels without sof after reset are dropped.
    for (int i = 0; i < 4; i++)
      drive(24'h808080, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    frame(0, 1'b1, 32, 0);
    frame(1, 1'b1, 32, 5);
    frame(2, 1'b1, 32, 0);
    frame(3, 1'b1, 32, 0);
    frame(4, 1'b0, 32, 0);
    idle(2);
    // Resync: a new sof arrives at pixel 13 of a running frame.
    frame(1, 1'b1, 13, 0);
    frame(1, 1'b1, 32, 0);
    idle(2);
    // Reset in place of pixel 20; in-flight pixels are discarded.
    frame(1, 1'b1, 20, 0);
    @(posedge clk); #1;
    rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
    q.delete();
    idle(2);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++)
      drive(24'hFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    frame(1, 1'b1, 32, 0);
    idle(6);
    fin = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
